ndp_result_upsizer: RTL

- Consumes the 32-bit AXI4-Stream result stream of the NDP core: 128 beats per frame, two fp16 lanes per beat.
- Optionally applies fp16 ReLU per lane.
- Packs word pairs into 64-bit beats and buffers them in a small FIFO before a 64-bit AXI4-Stream master towards the DMA/PS.
- Checks frame length against the expected beat count and keeps frame statistics.

---
 rtl/ndp_result_upsizer.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/ndp_result_upsizer.sv
// Generic FIFO with registered storage; the head entry drives the read side.
// Latency: a push is visible at pop_dat/pop_vld one cycle later.
// Backpressure: pop only on pop_vld & pop_rdy; push may coincide with pop when full.
module ndp_result_fifo #(
    parameter int WIDTH = 73,
    parameter int DEPTH = 4
) (
    input  logic                     axi_aclk,
    input  logic                     axi_aresetn,
    input  logic                     push_vld,
    input  logic [WIDTH-1:0]         push_dat,
    output logic                     pop_vld,
    output logic [WIDTH-1:0]         pop_dat,
    input  logic                     pop_rdy,
    output logic [$clog2(DEPTH):0]   count_nxt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push;
    logic             pop;

    assign pop     = pop_vld & pop_rdy;
    assign push    = push_vld & ((count != DEPTH_C) | pop);
    assign pop_vld = (count != '0);
    assign pop_dat = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // Storage is cleared so the read side shows zeros out of reset.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_nxt;
        end
    end
endmodule

// Upsizes the 32-bit NDP result stream to 64-bit beats with optional fp16 ReLU.
// Latency: pairing beat accepted at edge N appears on m_axis after edge N.
// Backpressure: registered s_axis_tready = FIFO has room for the next cycle.
module ndp_result_upsizer #(
    parameter int IN_WIDTH    = 32,
    parameter int LANE_WIDTH  = 16,
    parameter int FRAME_WORDS = 128,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                    axi_aclk,
    input  logic                    axi_aresetn,
    input  logic [IN_WIDTH-1:0]     s_axis_tdata,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tlast,
    output logic                    s_axis_tready,
    output logic [2*IN_WIDTH-1:0]   m_axis_tdata,
    output logic [IN_WIDTH/4-1:0]   m_axis_tkeep,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tlast,
    input  logic                    m_axis_tready,
    input  logic                    relu_en,
    input  logic                    clr_stats,
    output logic                    len_err,
    output logic [15:0]             frame_cnt
);
    localparam int OW    = 2 * IN_WIDTH;
    localparam int KEEPW = OW / 8;
    localparam int CNTW  = $clog2(FRAME_WORDS) + 1;
    localparam int FCW   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNTW-1:0]  LAST_IDX = CNTW'(FRAME_WORDS - 1);
    localparam logic [FCW-1:0]   DEPTH_C  = FCW'(FIFO_DEPTH);
    localparam logic [KEEPW-1:0] KEEP_LO  = {{(KEEPW/2){1'b0}}, {(KEEPW/2){1'b1}}};
    localparam logic [KEEPW-1:0] KEEP_ALL = '1;

    typedef struct packed {
        logic [OW-1:0]    dat;
        logic [KEEPW-1:0] keep;
        logic             last;
    } out_beat_t;

    typedef enum logic {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } pack_state_t;

    pack_state_t       state_q, state_d;
    logic [IN_WIDTH-1:0] low_q, low_d;
    logic [IN_WIDTH-1:0] word;
    logic [LANE_WIDTH-1:0] lane0, lane1;
    logic [CNTW-1:0]   beat_cnt_q;
    logic              relu_q;
    logic              relu_act;
    logic              s_ready_q;
    logic              acc;
    logic              set_err;
    logic              frame_done;
    logic              push_vld;
    out_beat_t         push_beat;
    out_beat_t         head;
    logic              fifo_vld;
    logic [$bits(out_beat_t)-1:0] fifo_dat;
    logic [FCW-1:0]    fifo_cnt_nxt;

    assign s_axis_tready = s_ready_q;
    assign acc           = s_axis_tvalid & s_ready_q;

    // relu_en is live on the first beat of a frame, then held for the rest.
    assign relu_act = (beat_cnt_q == '0) ? relu_en : relu_q;
    assign lane0    = s_axis_tdata[LANE_WIDTH-1:0];
    assign lane1    = s_axis_tdata[2*LANE_WIDTH-1:LANE_WIDTH];
    assign word     = {(relu_act & lane1[LANE_WIDTH-1]) ? '0 : lane1,
                       (relu_act & lane0[LANE_WIDTH-1]) ? '0 : lane0};

    assign set_err = acc & ((s_axis_tlast & (beat_cnt_q != LAST_IDX)) |
                            (~s_axis_tlast & (beat_cnt_q == LAST_IDX)));

    always_comb begin
        state_d   = state_q;
        low_d     = low_q;
        push_vld  = 1'b0;
        push_beat = '0;
        case (state_q)
            EMPTY: begin
                if (acc) begin
                    if (s_axis_tlast) begin
                        push_vld       = 1'b1;
                        push_beat.dat  = {{IN_WIDTH{1'b0}}, word};
                        push_beat.keep = KEEP_LO;
                        push_beat.last = 1'b1;
                    end else begin
                        low_d   = word;
                        state_d = HALF;
                    end
                end
            end
            HALF: begin
                if (acc) begin
                    push_vld       = 1'b1;
                    push_beat.dat  = {word, low_q};
                    push_beat.keep = KEEP_ALL;
                    push_beat.last = s_axis_tlast;
                    state_d        = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    ndp_result_fifo #(
        .WIDTH ($bits(out_beat_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .axi_aclk    (axi_aclk),
        .axi_aresetn (axi_aresetn),
        .push_vld    (push_vld),
        .push_dat    (push_beat),
        .pop_vld     (fifo_vld),
        .pop_dat     (fifo_dat),
        .pop_rdy     (m_axis_tready),
        .count_nxt   (fifo_cnt_nxt)
    );

    assign head          = out_beat_t'(fifo_dat);
    assign m_axis_tdata  = head.dat;
    assign m_axis_tkeep  = head.keep;
    assign m_axis_tlast  = head.last;
    assign m_axis_tvalid = fifo_vld;
    assign frame_done    = fifo_vld & m_axis_tready & head.last;

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q    <= EMPTY;
            low_q      <= '0;
            beat_cnt_q <= '0;
            relu_q     <= 1'b0;
            s_ready_q  <= 1'b0;
            len_err    <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            state_q   <= state_d;
            low_q     <= low_d;
            s_ready_q <= (fifo_cnt_nxt < DEPTH_C);
            if (acc && (beat_cnt_q == '0)) begin
                relu_q <= relu_en;
            end
            // Over-long frames keep counting until the counter saturates.
            if (acc) begin
                if (s_axis_tlast) begin
                    beat_cnt_q <= '0;
                end else if (beat_cnt_q != '1) begin
                    beat_cnt_q <= beat_cnt_q + 1'b1;
                end
            end
            if (clr_stats) begin
                len_err <= 1'b0;
            end else if (set_err) begin
                len_err <= 1'b1;
            end
            if (clr_stats) begin
                frame_cnt <= '0;
            end else if (frame_done) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end
endmodule
